// File: rtl/apb_req_initiator.sv
// APB requester: turns a single valid/ready request into one APB transfer and
// returns the result on a valid/ready response channel, with optional timeout.
module apb_req_initiator #(
    parameter int          ADDR_W  = 16,
    parameter int          DATA_W  = 32,
    parameter int          TIMEOUT = 255,
    parameter logic [2:0]  PROT    = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_strb,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_W-1:0]     p_addr,
    output logic [2:0]            p_prot,
    output logic                  p_sel,
    output logic                  p_enable,
    output logic                  p_write,
    output logic [DATA_W-1:0]     p_wdata,
    output logic [DATA_W/8-1:0]   p_strb,
    input  logic                  p_ready,
    input  logic [DATA_W-1:0]     p_rdata,
    input  logic                  p_slverr
);

    // The counter only has to hold completed wait cycles, i.e. at most TIMEOUT-1.
    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;

    assign p_prot = PROT;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            req_rdy     <= 1'b0;
            rsp_vld     <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            p_addr      <= '0;
            p_sel       <= 1'b0;
            p_enable    <= 1'b0;
            p_write     <= 1'b0;
            p_wdata     <= '0;
            p_strb      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    req_rdy <= 1'b1;
                    if (req_vld && req_rdy) begin
                        req_rdy  <= 1'b0;
                        p_sel    <= 1'b1;
                        p_addr   <= req_addr;
                        p_write  <= req_write;
                        p_wdata  <= req_wdata;
                        p_strb   <= req_write ? req_strb : '0;
                        wait_cnt <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    p_enable <= 1'b1;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // A ready completer wins over a timeout expiring on the same cycle.
                    if (p_ready) begin
                        p_sel       <= 1'b0;
                        p_enable    <= 1'b0;
                        rsp_vld     <= 1'b1;
                        rsp_rdata   <= (p_write || p_slverr) ? '0 : p_rdata;
                        rsp_err     <= p_slverr;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
                        p_sel       <= 1'b0;
                        p_enable    <= 1'b0;
                        rsp_vld     <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        req_rdy <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_initiator.sv
// Directed and randomized checks of apb_req_initiator against a transaction-level
// model: phase lengths, latency and response contents are predicted per request.
module tb_apb_req_initiator;

    localparam int         TIMEOUT = 4;
    localparam logic [2:0] PROT    = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_vld, req_rdy, req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_vld, rsp_rdy;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic [15:0] p_addr;
    logic [2:0]  p_prot;
    logic        p_sel, p_enable, p_write;
    logic [31:0] p_wdata;
    logic [3:0]  p_strb;
    logic        p_ready;
    logic [31:0] p_rdata;
    logic        p_slverr;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    apb_req_initiator #(
        .ADDR_W (16),
        .DATA_W (32),
        .TIMEOUT(TIMEOUT),
        .PROT   (PROT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_strb   (req_strb),
        .rsp_vld    (rsp_vld),
        .rsp_rdy    (rsp_rdy),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .p_addr     (p_addr),
        .p_prot     (p_prot),
        .p_sel      (p_sel),
        .p_enable   (p_enable),
        .p_write    (p_write),
        .p_wdata    (p_wdata),
        .p_strb     (p_strb),
        .p_ready    (p_ready),
        .p_rdata    (p_rdata),
        .p_slverr   (p_slverr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_rdy"},  req_rdy,     0);
        check({tag, "_rsp_vld"},  rsp_vld,     0);
        check({tag, "_rsp_err"},  rsp_err,     0);
        check({tag, "_rsp_to"},   rsp_timeout, 0);
        check({tag, "_rsp_rd"},   rsp_rdata,   0);
        check({tag, "_p_sel"},    p_sel,       0);
        check({tag, "_p_en"},     p_enable,    0);
        check({tag, "_p_write"},  p_write,     0);
        check({tag, "_p_addr"},   p_addr,      0);
        check({tag, "_p_wdata"},  p_wdata,     0);
        check({tag, "_p_strb"},   p_strb,      0);
    endtask

    // One complete request: 'waits' is how many ACCESS cycles pass with p_ready=0
    // before the completer answers; 'hold_next' keeps req_vld up during the response.
    task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int waits, input logic [31:0] rdata,
                           input logic slverr, input int rsp_delay, input logic hold_next);
        bit          to;
        int          n_acc, t_hs, guard;
        logic [31:0] e_rdata;
        logic        e_err;
        logic [3:0]  e_strb;

        to      = (TIMEOUT != 0) && (waits >= TIMEOUT);
        n_acc   = to ? TIMEOUT : waits + 1;
        e_strb  = wr ? strb : 4'h0;
        e_rdata = (to || wr || slverr) ? 32'h0 : rdata;
        e_err   = to ? 1'b1 : slverr;

        req_vld = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_strb = strb;
        guard = 0;
        while (req_rdy !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("req_rdy_wait", req_rdy, 1);
        t_hs = cyc;

        @(negedge clk);
        req_vld = 1'b0; req_addr = 16'($urandom); req_wdata = $urandom; req_strb = 4'($urandom);
        check("setup_sel",   p_sel,    1);
        check("setup_en",    p_enable, 0);
        check("setup_addr",  p_addr,   addr);
        check("setup_write", p_write,  wr);
        check("setup_wdata", p_wdata,  wdata);
        check("setup_strb",  p_strb,   e_strb);
        check("setup_rdy",   req_rdy,  0);
        check("setup_rsp",   rsp_vld,  0);

        for (int i = 0; i < n_acc; i++) begin
            @(negedge clk);
            check("acc_sel",   p_sel,    1);
            check("acc_en",    p_enable, 1);
            check("acc_addr",  p_addr,   addr);
            check("acc_wdata", p_wdata,  wdata);
            check("acc_strb",  p_strb,   e_strb);
            check("acc_rsp",   rsp_vld,  0);
            p_ready  = (i == waits);
            p_rdata  = (i == waits) ? rdata : $urandom;
            p_slverr = (i == waits) ? slverr : 1'($urandom);
        end

        @(negedge clk);
        p_ready = 1'b0; p_rdata = $urandom; p_slverr = 1'($urandom);
        check("latency",   cyc - t_hs, 2 + n_acc);
        check("rsp_vld",   rsp_vld,     1);
        check("rsp_rdata", rsp_rdata,   e_rdata);
        check("rsp_err",   rsp_err,     e_err);
        check("rsp_to",    rsp_timeout, to);
        check("rsp_sel",   p_sel,       0);
        check("rsp_en",    p_enable,    0);
        check("rsp_rdy",   req_rdy,     0);
        rsp_rdy = 1'b0;
        if (hold_next) req_vld = 1'b1;
        for (int d = 0; d < rsp_delay; d++) begin
            @(negedge clk);
            check("bp_vld",   rsp_vld,     1);
            check("bp_rdata", rsp_rdata,   e_rdata);
            check("bp_err",   rsp_err,     e_err);
            check("bp_to",    rsp_timeout, to);
            check("bp_rdy",   req_rdy,     0);
        end
        rsp_rdy = 1'b1;

        @(negedge clk);
        rsp_rdy = 1'b0;
        check("idle_vld",  rsp_vld, 0);
        check("idle_rdy",  req_rdy, 1);
        check("idle_sel",  p_sel,   0);
        check("idle_addr", p_addr,  addr);
        check("idle_strb", p_strb,  e_strb);
    endtask

    initial begin
        rst_n = 1'b0; req_vld = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_strb = '0; rsp_rdy = 1'b0; p_ready = 1'b0; p_rdata = '0; p_slverr = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        check("p_prot", p_prot, PROT);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_rdy", req_rdy, 1);
        check("release_vld", rsp_vld, 0);

        // Zero-wait write, two-wait read, slave error, timeout, ready-on-last-cycle priority.
        run_txn(1'b1, 16'h0010, 32'hA5A5_5A5A, 4'hF, 0, 32'h0,         1'b0, 0, 1'b0);
        run_txn(1'b0, 16'h0004, 32'h0,         4'hF, 2, 32'h1234_5678, 1'b0, 0, 1'b0);
        run_txn(1'b0, 16'h0008, 32'h0,         4'h3, 1, 32'hDEAD_BEEF, 1'b1, 0, 1'b0);
        run_txn(1'b1, 16'h0020, 32'h0BAD_F00D, 4'h5, 9, 32'h0,         1'b0, 0, 1'b0);
        run_txn(1'b0, 16'h0024, 32'h0,         4'h0, 0, 32'hCAFE_0001, 1'b0, 0, 1'b0);
        run_txn(1'b0, 16'h0028, 32'h0,         4'h0, TIMEOUT - 1, 32'h7777_1111, 1'b0, 0, 1'b0);

        // Backpressure with the next request already waiting.
        run_txn(1'b1, 16'h0030, 32'h1111_2222, 4'h9, 1, 32'h0,         1'b0, 5, 1'b1);
        run_txn(1'b0, 16'h0034, 32'h0,         4'hF, 0, 32'h3333_4444, 1'b0, 2, 1'b0);

        // Reset while in ACCESS: no response may appear.
        req_vld = 1'b1; req_write = 1'b1; req_addr = 16'h0040; req_wdata = 32'h5555_AAAA;
        req_strb = 4'hF;
        @(negedge clk);
        req_vld = 1'b0;
        @(negedge clk);
        check("rst_acc_en", p_enable, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_acc");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_rdy", req_rdy, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_rsp", rsp_vld, 0);
            check("rst_no_sel", p_sel,   0);
        end

        for (int n = 0; n < 24; n++) begin
            run_txn(1'($urandom), 16'($urandom), $urandom, 4'($urandom),
                    $urandom_range(0, TIMEOUT + 2), $urandom, 1'($urandom),
                    $urandom_range(0, 3), (n != 23) ? 1'($urandom) : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_req_initiator.md
APB_REQ_INITIATOR -- requirements
Module: apb_req_initiator

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width, a multiple of 8.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum ACCESS wait cycles; 0 disables the timeout.
REQ-004 SHALL have parameter PROT, default 3'b000, constant value driven on p_prot.
REQ-005 SHALL have ports, in order:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_vld  in  1  request valid.
- req_rdy  out  1  request accepted when high together with req_vld.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- req_strb  in  DATA_W/8  write byte strobes.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  p_slverr sampled at completion, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- p_addr  out  ADDR_W  APB address.
- p_prot  out  3  APB protection, equals PROT.
- p_sel  out  1  APB select.
- p_enable  out  1  APB enable.
- p_write  out  1  APB direction.
- p_wdata  out  DATA_W  APB write data.
- p_strb  out  DATA_W/8  APB strobes; all zero for reads.
- p_ready  in  1  APB completer ready.
- p_rdata  in  DATA_W  APB read data.
- p_slverr  in  1  APB error.

Function
REQ-006 SHALL implement an FSM with states IDLE, SETUP, ACCESS and RESP; all outputs except p_prot SHALL be driven from registers.
REQ-007 SHALL drive req_rdy=1 only in IDLE; a handshake (req_vld&&req_rdy) SHALL capture addr/write/wdata/strb and move to SETUP on the next cycle.
REQ-008 In SETUP, SHALL drive p_sel=1 and p_enable=0, then move unconditionally to ACCESS.
REQ-009 In ACCESS, SHALL drive p_sel=1 and p_enable=1 and hold p_addr, p_write, p_wdata and p_strb stable from SETUP until completion.
REQ-010 When p_ready=1 is sampled in ACCESS, SHALL register rsp_rdata (p_rdata for reads, 0 for writes) and rsp_err=p_slverr, deassert p_sel and p_enable on the next cycle, and enter RESP.
REQ-011 SHALL count ACCESS cycles with p_ready=0; when TIMEOUT!=0 and the count reaches TIMEOUT, SHALL enter RESP with rsp_err=1, rsp_timeout=1 and rsp_rdata=0, deasserting p_sel and p_enable.
REQ-012 p_ready sampled high on the same cycle the count reaches TIMEOUT SHALL take priority: normal completion, rsp_timeout=0.
REQ-013 In RESP, SHALL hold rsp_vld=1 and the response stable until rsp_rdy=1, then return to IDLE and clear rsp_vld on the next cycle.
REQ-014 Minimum request-to-response latency SHALL be 3 cycles (handshake at T, SETUP at T+1, ACCESS at T+2 with p_ready=1, rsp_vld at T+3); each ACCESS wait cycle SHALL add 1.
REQ-015 SHALL never accept a new request while a transfer or response is outstanding (at most one transaction in flight).
REQ-016 p_addr, p_wdata and p_strb in IDLE SHALL retain their last values; p_sel and p_enable SHALL be 0 outside SETUP and ACCESS.
REQ-017 p_slverr and p_rdata SHALL be ignored except on the cycle p_ready=1 is sampled in ACCESS.

Reset
REQ-018 rst_n=0 at a rising edge SHALL force IDLE and clear the timeout counter, and SHALL drive req_rdy=0, rsp_vld=0, rsp_err=0, rsp_timeout=0, rsp_rdata=0, p_sel=0, p_enable=0, p_write=0, p_addr=0, p_wdata=0 and p_strb=0; req_rdy SHALL go to 1 on the first cycle after release.
REQ-019 Reset asserted mid-transfer SHALL abort the transfer without producing a response.

Verification
REQ-020 Write with no wait states: addr=0x0010, wdata=0xA5A5_5A5A, strb=0xF, p_ready=1 -> p_sel rises at T+1, p_enable high at T+2 only; rsp_vld at T+3 with rsp_err=0 and rsp_rdata=0.
REQ-021 Read with 2 wait cycles: addr=0x0004, p_rdata=0x1234_5678 when p_ready=1 -> rsp_vld at T+5 with rsp_rdata=0x1234_5678; p_strb=0; p_addr stable throughout.
REQ-022 Slave error: read with p_slverr=1 on the p_ready cycle -> rsp_err=1 and rsp_timeout=0.
REQ-023 Timeout with TIMEOUT=4 and p_ready held at 0 -> after 4 ACCESS cycles, rsp_vld=1, rsp_err=1, rsp_timeout=1, p_sel=0; the next request proceeds normally.
REQ-024 Backpressure: rsp_rdy=0 for 5 cycles with req_vld held high -> req_rdy=0 and rsp_* stable throughout; the second request is accepted the cycle after IDLE is re-entered.
REQ-025 Reset in ACCESS: rst_n=0 for 1 cycle -> all outputs at their reset values next cycle, no rsp_vld pulse, req_rdy=1 after release.
